// File: rtl/io_host_bridge_if.sv
// rtl/io_host_bridge_if.sv - CPU register bus between host CPU and io_host_bridge
interface io_host_bridge_if;
    logic        cpu_read_en;
    logic        cpu_write_en;
    logic [1:0]  cpu_addr;
    logic [31:0] cpu_write_data;
    logic [31:0] cpu_read_data;
    logic        cpu_ready;

    modport master (
        output cpu_read_en,
        output cpu_write_en,
        output cpu_addr,
        output cpu_write_data,
        input  cpu_read_data,
        input  cpu_ready
    );

    modport slave (
        input  cpu_read_en,
        input  cpu_write_en,
        input  cpu_addr,
        input  cpu_write_data,
        output cpu_read_data,
        output cpu_ready
    );
endinterface

// File: rtl/io_host_bridge.sv
// rtl/io_host_bridge.sv - CPU register bridge with device RX FIFO and TX byte strobe
module io_host_bridge #(
    parameter int RX_DEPTH = 4
) (
    input  logic               clk,
    input  logic               rst_n,
    io_host_bridge_if.slave    cpu,
    input  logic [7:0]         dev_output_value,
    input  logic               dev_output_trigger,
    output logic               dev_read_ready_trigger,
    output logic [7:0]         dev_input_value,
    output logic               dev_input_trigger
);
    localparam int AW = $clog2(RX_DEPTH);
    localparam int CW = AW + 1;

    localparam logic [1:0] ADDR_STATUS  = 2'd0;
    localparam logic [1:0] ADDR_RX_DATA = 2'd1;
    localparam logic [1:0] ADDR_TX_DATA = 2'd2;
    localparam logic [1:0] ADDR_CONTROL = 2'd3;

    logic [7:0]    rx_mem [RX_DEPTH];
    logic [AW-1:0] rd_ptr;
    logic [AW-1:0] wr_ptr;
    logic [CW-1:0] count;
    logic          overflow;

    logic          full;
    logic          rd_req;
    logic          wr_req;
    logic          push;
    logic          pop;
    logic          ovf_event;
    logic          ovf_clear;
    logic [31:0]   status_word;
    logic          unused_wdata;

    assign unused_wdata = ^cpu.cpu_write_data[31:8];

    // Decode this cycle's requests; a write always wins over a simultaneous read.
    always_comb begin
        full      = (count == CW'(RX_DEPTH));
        wr_req    = cpu.cpu_write_en;
        rd_req    = cpu.cpu_read_en && !cpu.cpu_write_en;
        push      = dev_output_trigger && !full;
        ovf_event = dev_output_trigger && full;
        pop       = rd_req && (cpu.cpu_addr == ADDR_RX_DATA) && (count != '0);
        ovf_clear = wr_req && (cpu.cpu_addr == ADDR_CONTROL) && cpu.cpu_write_data[0];
        status_word      = '0;
        status_word[0]   = (count != '0);
        status_word[1]   = full;
        status_word[2]   = overflow;
        status_word[8:4] = 5'(count);
    end

    assign dev_read_ready_trigger = !full;

    // Receive FIFO storage; contents are don't-care until counted in.
    always_ff @(posedge clk) begin
        if (rst_n && push) begin
            rx_mem[wr_ptr] <= dev_output_value;
        end
    end

    // FIFO pointers, occupancy and sticky overflow; a new overflow beats a clear.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            rd_ptr   <= '0;
            wr_ptr   <= '0;
            count    <= '0;
            overflow <= 1'b0;
        end else begin
            if (push) wr_ptr <= wr_ptr + 1'b1;
            if (pop)  rd_ptr <= rd_ptr + 1'b1;
            case ({push, pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
            if (ovf_event) begin
                overflow <= 1'b1;
            end else if (ovf_clear) begin
                overflow <= 1'b0;
            end
        end
    end

    // Registered CPU response: one-cycle latency for both reads and writes.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            cpu.cpu_read_data <= '0;
            cpu.cpu_ready     <= 1'b0;
        end else begin
            cpu.cpu_ready <= cpu.cpu_read_en || cpu.cpu_write_en;
            if (rd_req) begin
                case (cpu.cpu_addr)
                    ADDR_STATUS:  cpu.cpu_read_data <= status_word;
                    ADDR_RX_DATA: cpu.cpu_read_data <= pop ? {24'd0, rx_mem[rd_ptr]} : 32'd0;
                    default:      cpu.cpu_read_data <= 32'd0;
                endcase
            end
        end
    end

    // Transmit path: each TX_DATA write yields one strobe; the value is held afterwards.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            dev_input_value   <= 8'd0;
            dev_input_trigger <= 1'b0;
        end else begin
            dev_input_trigger <= 1'b0;
            if (wr_req && (cpu.cpu_addr == ADDR_TX_DATA)) begin
                dev_input_value   <= cpu.cpu_write_data[7:0];
                dev_input_trigger <= 1'b1;
            end
        end
    end
endmodule
